pending_encoder_8to3: RTL
=========================

# pending_encoder_8to3

Sequential 8-to-3 encoder: captures requests on eight one-hot select lines into a pending register and presents them one at a time as a 3-bit index under a valid/ready handshake. It is the inverse of the register file's 3-to-8 write-select decode. Event sources such as buttons, timers and score-register writes are collapsed into a single indexed stream for the game controller. Each pending request is cleared when it is accepted.

## Interface
- ROUND_ROBIN, 0: 0 = fixed priority, lowest index wins; 1 = rotating priority, search starts after the last granted index.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- Enable  input  1  when low, REQ is ignored; pending state and handshake continue to run.
- REQ  input  8  request lines; REQ[i]=1 in any cycle with Enable=1 sets pending bit i.
- READY  input  1  consumer accepts OUT when VALID=1 and READY=1 in the same cycle.
- OUT  output  3  index of the presented request; held stable while VALID=1 and READY=0.
- VALID  output  1  OUT holds a pending request.
- PENDING  output  8  current pending register.
- OVERFLOW  output  1  sticky; a request arrived for a bit that was already pending and not being cleared.

## Operation
- Pending register P: P_next = (P & ~clr) | (REQ & {8{Enable}}). clr is the one-hot of OUT on a handshake and 0 otherwise. A set and a clear on the same bit in the same cycle resolve to set, so the bit re-pends.
- Selection operates on the registered P only, never on same-cycle REQ.
- Candidate set S = P, or P & ~onehot(OUT) in a handshake cycle.
- Fixed mode: pick the lowest set bit of S.
- Round-robin mode: pick the first set bit of S scanning (ptr+1) mod 8 upward, wrapping 7 to 0. ptr is the last granted index and updates on each handshake.
- FSM IDLE:
  - P != 0: load OUT = pick(P), set VALID=1, go to PRESENT.
  - Otherwise stay in IDLE with VALID=0.
- FSM PRESENT:
  - No handshake: hold OUT and VALID.
  - Handshake and S != 0: load OUT = pick(S) and stay in PRESENT; VALID stays 1.
  - Handshake and S == 0: VALID=0, go to IDLE.
- OVERFLOW sets when Enable & REQ[i] & P[i] & ~clr[i] for any i. Only reset clears it.
- Enable=0 in PRESENT does not drop VALID.
- Reset values: P=0, OUT=0, VALID=0, OVERFLOW=0, PENDING=0, ptr=7, state=IDLE.
- Reset asserted mid-transaction: VALID=0 and P=0 on the next edge. Any in-flight or pending requests are discarded with no handshake.

## Timing
- All outputs are registered, with no combinational path from REQ or READY to any output.
- Latency from idle: REQ in cycle 0, PENDING bit visible in cycle 1, VALID/OUT in cycle 2.
- Back-to-back: handshake in cycle n, next index presented in cycle n+1, so sustained throughput is one grant per cycle.
- Request to the just-granted bit in handshake cycle n: visible in PENDING at n+1, eligible for selection at n+1, presented no earlier than n+2.
- OUT changes only on entry to PRESENT or in the cycle after a handshake.

## Structure
- Shared package holds:
  - state enum {IDLE, PRESENT};
  - constants N_REQ=8 and IDX_W=3;
  - ptr reset value 3'd7.
- Sub-module priority_pick8: combinational. It takes an 8-bit vector and a 3-bit start index and returns found plus a 3-bit index. It is built as rotate right by start, find first set, then add start mod 8. Fixed mode ties start to 0.
- One-hot clear mask comes from the registered OUT, gated by the handshake.

## Test plan
- Reset then REQ=8'b0010_0100 for one cycle, READY=1, fixed mode -> OUT=2 in cycle 2, OUT=5 in cycle 3, VALID=0 in cycle 4, PENDING=0.
- READY=0 with REQ=8'h81 -> VALID=1, OUT=0 held for 10 cycles. Raise READY -> OUT=7 the next cycle, then idle.
- ROUND_ROBIN=1 with REQ held at 8'hFF and READY=1 -> OUT sequence 0,1,...,7,0,1 with no gaps.
- Handshake on OUT=3 while REQ[3]=1 in the same cycle -> PENDING[3] stays 1, OVERFLOW stays 0, 3 is presented again.
- REQ[4] pulsed twice while pending and not granted -> OVERFLOW=1 and stays 1 through grants until reset. With Enable=0, REQ=8'hFF produces no PENDING change.
- reset asserted while VALID=1 and PENDING=8'h0F -> next cycle VALID=0, PENDING=0, OUT=0. After reset, REQ[6] is presented as OUT=6 with ptr restarted.

Source files
------------

// File: rtl/pending_encoder_8to3_pkg.sv
// Shared types and constants for the pending request encoder.
// Imported by the picker and the top level.
package pending_encoder_8to3_pkg;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] PTR_RST = 3'd7;

endpackage

// File: rtl/pending_encoder_8to3_priority_pick8.sv
// Find-first-set over an 8-bit vector, scanning upward from a start index.
// Rotate right by start, take the lowest set bit, then add start back.
module priority_pick8
  import pending_encoder_8to3_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   ffs;

  always_comb begin
    dbl = {vec, vec} >> start;
    rot = dbl[N_REQ-1:0];
    ffs = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) ffs = IDX_W'(i);
    end
    found = |vec;
    idx   = ffs + start;
  end

endmodule

// File: rtl/pending_encoder_8to3.sv
// Collects one-hot requests into a pending set and streams them out
// one index at a time under a valid/ready handshake.
module pending_encoder_8to3
  import pending_encoder_8to3_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic [N_REQ-1:0] REQ,
  input  logic             READY,
  output logic [IDX_W-1:0] OUT,
  output logic             VALID,
  output logic [N_REQ-1:0] PENDING,
  output logic             OVERFLOW
);

  state_t             state;
  logic [N_REQ-1:0]   p;
  logic [IDX_W-1:0]   ptr;
  logic               hs;
  logic [N_REQ-1:0]   clr;
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   cand;
  logic [IDX_W-1:0]   start;
  logic               found;
  logic [IDX_W-1:0]   pidx;

  assign hs   = VALID & READY;
  assign clr  = hs ? (N_REQ'(1) << OUT) : '0;
  assign req  = REQ & {N_REQ{Enable}};
  assign cand = p & ~clr;

  // In a handshake cycle the granted index is the new pointer.
  always_comb begin
    start = '0;
    if (ROUND_ROBIN) begin
      start = hs ? OUT + 3'd1 : ptr + 3'd1;
    end
  end

  priority_pick8 u_pick (
    .vec   (cand),
    .start (start),
    .found (found),
    .idx   (pidx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      p        <= '0;
      ptr      <= PTR_RST;
      OUT      <= '0;
      VALID    <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      p <= cand | req;
      if (|(req & cand)) OVERFLOW <= 1'b1;
      if (hs) ptr <= OUT;
      case (state)
        IDLE: begin
          if (found) begin
            OUT   <= pidx;
            VALID <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (hs) begin
            if (found) begin
              OUT <= pidx;
            end else begin
              VALID <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign PENDING = p;

endmodule
